// File: rtl/bit_sched_64b.sv
// -----------------------------------------------------------------------------
// bit_sched_64b
//
// Purpose:
//   Walks a 64-bit job bitmap and hands out the index of every set bit, lowest
//   index first, one per valid/ready beat. Each granted bit is cleared from the
//   pending mask. A registered priority encoder runs in a one-cycle ENC state
//   ahead of every OUT state, so the best throughput is one index per two
//   cycles.
//
// Ports:
//   clk_i        clock
//   rst_n_i      asynchronous active-low reset
//   start_i      job start strobe, only sampled in IDLE
//   abort_i      abandon the current job (no done pulse), ignored in IDLE
//   mask_i       job bitmap, captured on an accepted start
//   busy_o       high in every state except IDLE (registered)
//   idx_valid_o  idx_o holds a granted index (OUT state only)
//   idx_ready_i  consumer accepts idx_o
//   idx_o        lowest set index of the pending mask
//   idx_last_o   idx_o is the final index of the job
//   done_o       one-cycle pulse when the job completes
//   cnt_o        beats completed in the current job (optional, see below)
//
// Configuration:
//   BIT_SCHED_CNT_EN  when defined, adds the 7-bit cnt_o beat counter.
// -----------------------------------------------------------------------------
module bit_sched_64b (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [63:0] mask_i,
  output logic        busy_o,
  output logic        idx_valid_o,
  input  logic        idx_ready_i,
  output logic [5:0]  idx_o,
  output logic        idx_last_o,
  output logic        done_o
`ifdef BIT_SCHED_CNT_EN
  ,
  output logic [6:0]  cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pending_q, pending_d;
  logic [5:0]  idx_q, idx_d;
  logic        last_q, last_d;
  logic        busy_q;

  logic [5:0]  encIdx;
  logic        encLast;
  logic        beat;
  logic        startAcc;
  logic        abortAcc;

  assign beat     = (state_q == OUT) && idx_ready_i;
  assign startAcc = (state_q == IDLE) && start_i;
  assign abortAcc = (state_q != IDLE) && abort_i;

  // Lowest-set-bit encoder; scanning downwards lets the lowest hit win.
  always_comb begin
    encIdx = 6'd0;
    for (int i = 63; i >= 0; i--) begin
      if (pending_q[i]) begin
        encIdx = 6'(i);
      end
    end
    encLast = ((pending_q & ~(64'd1 << encIdx)) == 64'd0);
  end

  // State register plus the registered datapath.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (mask_i != 64'd0) ? ENC : DONE;
        end
      end
      ENC:  state_d = OUT;
      OUT: begin
        if (beat) begin
          state_d = last_q ? DONE : ENC;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abortAcc) begin
      state_d = IDLE;
    end
  end

  // Pending mask and encoder result registers. The encoder result is only
  // captured in ENC so that idx_o/idx_last_o stay frozen while OUT stalls.
  always_comb begin
    pending_d = pending_q;
    idx_d     = idx_q;
    last_d    = last_q;
    if (startAcc) begin
      pending_d = mask_i;
    end
    if (state_q == ENC) begin
      idx_d  = encIdx;
      last_d = encLast;
    end
    if (beat) begin
      pending_d = pending_q & ~(64'd1 << idx_q);
    end
    if (abortAcc) begin
      pending_d = '0;
    end
  end

  // Output decode.
  always_comb begin
    idx_valid_o = (state_q == OUT);
    idx_o       = (state_q == OUT) ? idx_q : 6'd0;
    idx_last_o  = (state_q == OUT) && last_q;
    done_o      = (state_q == DONE);
    busy_o      = busy_q;
  end

`ifdef BIT_SCHED_CNT_EN
  logic [6:0] cnt_q, cnt_d;

  // Seven bits so a full 64-bit job can report 64 beats.
  always_comb begin
    cnt_d = cnt_q;
    if (startAcc) begin
      cnt_d = 7'd0;
    end
    if (beat) begin
      cnt_d = cnt_q + 7'd1;
    end
    if (abortAcc) begin
      cnt_d = 7'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_bit_sched_64b.sv
// -----------------------------------------------------------------------------
// tb_bit_sched_64b
//
// Self-checking bench for bit_sched_64b. The reference model turns each job
// mask into a queue of expected indices and tracks, cycle by cycle, when the
// next index or the done pulse is due. Inputs are driven 1 time unit after
// the rising edge and outputs are sampled on the falling edge.
// Define BIT_SCHED_CNT_EN to also check cnt_o.
// -----------------------------------------------------------------------------
module tb_bit_sched_64b;

  logic        clk;
  logic        rstN;
  logic        start;
  logic        abort;
  logic [63:0] mask;
  logic        busy;
  logic        idxValid;
  logic        idxReady;
  logic [5:0]  idx;
  logic        idxLast;
  logic        done;
`ifdef BIT_SCHED_CNT_EN
  logic [6:0]  cnt;
`endif

  int checks   = 0;
  int failures = 0;

  bit_sched_64b dut (
    .clk_i       (clk),
    .rst_n_i     (rstN),
    .start_i     (start),
    .abort_i     (abort),
    .mask_i      (mask),
    .busy_o      (busy),
    .idx_valid_o (idxValid),
    .idx_ready_i (idxReady),
    .idx_o       (idx),
    .idx_last_o  (idxLast),
    .done_o      (done)
`ifdef BIT_SCHED_CNT_EN
    ,
    .cnt_o       (cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one job and checks every cycle against the queue model.
  task automatic run_job(input logic [63:0] jobMask, input int readyPct, input string name);
    int q[$];
    int total;
    int expValidAt;
    int expDoneAt;
    bit finished;
    bit expValid;
    for (int i = 0; i < 64; i++) begin
      if (jobMask[i]) q.push_back(i);
    end
    total      = q.size();
    expValidAt = (total != 0) ? 2 : -1;
    expDoneAt  = (total != 0) ? -1 : 1;
    finished   = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    mask  = jobMask;
    @(posedge clk); #1;
    start = 1'b0;
    mask  = {$urandom, $urandom};
    for (int cyc = 1; cyc <= 1000 && !finished; cyc++) begin
      idxReady = ($urandom_range(99) < readyPct);
      @(negedge clk);
      expValid = (cyc == expValidAt);
      checks++;
      if (idxValid !== expValid) begin
        failures++;
        $display("[TB] FAIL %s valid cyc=%0d got=%b exp=%b", name, cyc, idxValid, expValid);
      end
      checks++;
      if (done !== (cyc == expDoneAt)) begin
        failures++;
        $display("[TB] FAIL %s done cyc=%0d got=%b exp=%b", name, cyc, done, (cyc == expDoneAt));
      end
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL %s busy cyc=%0d got=%b exp=1", name, cyc, busy);
      end
`ifdef BIT_SCHED_CNT_EN
      checks++;
      if (cnt !== 7'(total - q.size())) begin
        failures++;
        $display("[TB] FAIL %s cnt cyc=%0d got=%0d exp=%0d", name, cyc, cnt, total - q.size());
      end
`endif
      if (expValid && q.size() > 0) begin
        checks++;
        if (idx !== 6'(q[0])) begin
          failures++;
          $display("[TB] FAIL %s idx cyc=%0d got=%0d exp=%0d", name, cyc, idx, q[0]);
        end
        checks++;
        if (idxLast !== (q.size() == 1)) begin
          failures++;
          $display("[TB] FAIL %s last cyc=%0d got=%b exp=%b", name, cyc, idxLast, (q.size() == 1));
        end
        if (idxReady) begin
          void'(q.pop_front());
          if (q.size() == 0) expDoneAt = cyc + 1;
          else expValidAt = cyc + 2;
        end else begin
          expValidAt = cyc + 1;
        end
      end
      if (cyc == expDoneAt) finished = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (!finished) begin
      failures++;
      $display("[TB] FAIL %s timeout got=running exp=done", name);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || idxValid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s idle_after got=busy%b/done%b/valid%b exp=0/0/0", name, busy, done, idxValid);
    end
    idxReady = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0; start = 1'b0; abort = 1'b0; mask = '0; idxReady = 1'b0;
    #23;
    checks++;
    if ({busy, idxValid, idx, idxLast, done} !== 10'd0) begin
      failures++;
      $display("[TB] FAIL reset outputs got=%b exp=0", {busy, idxValid, idx, idxLast, done});
    end
`ifdef BIT_SCHED_CNT_EN
    checks++;
    if (cnt !== 7'd0) begin
      failures++;
      $display("[TB] FAIL reset cnt got=%0d exp=0", cnt);
    end
`endif
    @(negedge clk);
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, idxValid, done} !== 3'd0) begin
      failures++;
      $display("[TB] FAIL reset idle got=%b exp=000", {busy, idxValid, done});
    end
  endtask

  task automatic test_directed_jobs();
    run_job(64'h0, 100, "zero_mask");
    run_job(64'h8000_0000_0000_0011, 100, "sparse");
    run_job(64'hFFFF_FFFF_FFFF_FFFF, 100, "full");
    run_job(64'h8000_0000_0000_0000, 100, "bit63");
  endtask

  task automatic test_ready_hold();
    @(posedge clk); #1;
    start = 1'b1; mask = 64'h0000_0100_0000_0000; idxReady = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (idxValid !== 1'b1 || idx !== 6'd40 || idxLast !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL hold c=%0d got=v%b/i%0d/l%b/d%b exp=1/40/1/0", c, idxValid, idx, idxLast, done);
      end
      @(posedge clk); #1;
    end
    idxReady = 1'b1;
    @(posedge clk); #1;
    idxReady = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || idxValid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hold_done got=d%b/v%b exp=1/0", done, idxValid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hold_idle got=d%b/b%b exp=0/0", done, busy);
    end
  endtask

  task automatic test_abort();
    @(posedge clk); #1;
    start = 1'b1; mask = 64'h0F; idxReady = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    idxReady = 1'b1;
    @(posedge clk); #1;
    idxReady = 1'b0;
    @(posedge clk); #1;
    // Second OUT: abort together with a start that must be ignored.
    abort = 1'b1; start = 1'b1; mask = 64'hFF00;
    @(negedge clk);
    checks++;
    if (idxValid !== 1'b1 || idx !== 6'd1 || idxLast !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_out got=v%b/i%0d/l%b exp=1/1/0", idxValid, idx, idxLast);
    end
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || idxValid !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL abort_idle c=%0d got=b%b/v%b/d%b exp=0/0/0", c, busy, idxValid, done);
      end
`ifdef BIT_SCHED_CNT_EN
      checks++;
      if (cnt !== 7'd0) begin
        failures++;
        $display("[TB] FAIL abort_cnt got=%0d exp=0", cnt);
      end
`endif
      @(posedge clk); #1;
    end
    run_job(64'h0000_0000_0000_0C01, 100, "after_abort");
  endtask

  task automatic test_reset_mid_job();
    @(posedge clk); #1;
    start = 1'b1; mask = 64'h8000_0001_0000_0004; idxReady = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (idxValid !== 1'b1 || idx !== 6'd2) begin
      failures++;
      $display("[TB] FAIL rst_mid_out got=v%b/i%0d exp=1/2", idxValid, idx);
    end
    #1 rstN = 1'b0;
    #1;
    checks++;
    if ({busy, idxValid, idx, idxLast, done} !== 10'd0) begin
      failures++;
      $display("[TB] FAIL rst_mid outputs got=%b exp=0", {busy, idxValid, idx, idxLast, done});
    end
    @(negedge clk);
    rstN = 1'b1;
    run_job(64'h2, 100, "after_reset");
  endtask

  task automatic test_random();
    logic [63:0] m;
    for (int n = 0; n < 12; n++) begin
      m = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      if (n % 3 == 0) m = m & {$urandom, $urandom};
      run_job(m, 30 + $urandom_range(70), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed_jobs();
    test_ready_hold();
    test_abort();
    test_reset_mid_job();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
